uart_tx: RTL and testbench

Transmit half of the USB-serial UART PMOD link: serialises one byte per valid/ready handshake onto the TXD line as 8N1 (or 8E1) with LSB first. It honours the host's CTS# flow control. It sits beside `uart_rx` in `top`, driving PMODL3 (TXD) and sampling PMODL2 (CTS#), and runs from the same 12 MHz CLK.

---
 rtl/uart_tx.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : Transmit half of the USB-serial UART PMOD link. Serialises
//                one byte per valid/ready handshake onto TXD as 8N1 (or 8E1
//                when UART_TX_PARITY_EN is defined), LSB first. New frames
//                are only accepted while the host asserts CTS# (active low).
//  Config macro: UART_TX_PARITY_EN - adds an even parity bit after bit 7.
//  Parameters  : CLKS_PER_BIT - CLK cycles per bit period (>= 2)
//                STOP_BITS    - number of stop bits (1 or 2)
//  Ports       : CLK     in   system clock, rising edge
//                reset   in   synchronous active-high reset
//                data_in in   byte to send, sampled on an accepting edge
//                valid   in   data_in offered this cycle
//                ready   out  transmitter can accept a byte this cycle
//                cts     in   CTS# from host, active low, asynchronous
//                tx      out  serial TXD line, idle high
//                done    out  one-cycle pulse when a frame completes
//                busy    out  frame in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int STOP_BITS    = 1
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    input  logic       cts,
    output logic       tx,
    output logic       done,
    output logic       busy
);

    localparam int              CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       c_STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

    state_t            r_state, w_state_next;
    logic              r_cts_meta, r_cts_s;
    logic [7:0]        r_shift, w_shift_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [2:0]        r_idx, w_idx_next;
    logic              r_tx, w_tx_next;
    logic              r_done, w_done_next;
    logic              r_busy;
    logic              w_accept;
    logic              w_bit_end;
`ifdef UART_TX_PARITY_EN
    logic              r_parity;
`endif

    assign ready = (r_state == S_IDLE) && !r_cts_s;
    assign tx    = r_tx;
    assign done  = r_done;
    assign busy  = r_busy;

    assign w_accept  = valid && ready;
    assign w_bit_end = (r_cnt == c_CNT_LAST);

    // CTS# synchroniser; resets to "deasserted" so nothing is accepted
    // until the host's level has been sampled twice.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_cts_meta <= 1'b1;
            r_cts_s    <= 1'b1;
        end else begin
            r_cts_meta <= cts;
            r_cts_s    <= r_cts_meta;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shift <= 8'h00;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_tx    <= w_tx_next;
            r_done  <= w_done_next;
            r_busy  <= (w_state_next != S_IDLE);
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^data_in;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_done_next  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_shift_next = data_in;
                    w_cnt_next   = '0;
                    w_idx_next   = 3'd0;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt_next   = '0;
                    w_state_next = S_DATA;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_ONE;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_next   = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    // Index wraps 7->0 so STOP reuses it as the stop-bit count.
                    w_idx_next   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end
                end else begin
                    w_cnt_next = r_cnt + c_CNT_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_cnt_next   = '0;
                    w_state_next = S_STOP;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_ONE;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_next = '0;
                    if (r_idx == c_STOP_LAST) begin
                        w_idx_next   = 3'd0;
                        w_state_next = S_IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // TXD is registered from the next state so the line level changes on the
    // same edge as the state, e.g. the start bit begins on the accepting edge.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_next = r_parity;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Directed self-checking bench for uart_tx. Instance u_dut
//                runs 4 clocks/bit with 1 stop bit, u_dut2 runs 8 clocks/bit
//                with 2 stop bits. Honours UART_TX_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int CPB    = 4;
    localparam int FRAME  = (1 + 8 + PB + 1) * CPB;
    localparam int CPB2   = 8;
    localparam int FRAME2 = (1 + 8 + PB + 2) * CPB2;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       cts = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid = 1'b0;
    logic       ready, tx, done, busy;
    logic [7:0] data2 = 8'h00;
    logic       valid2 = 1'b0;
    logic       ready2, tx2, done2, busy2;

    int checks = 0;
    int errors = 0;

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut (
        .CLK(CLK), .reset(reset), .data_in(data_in), .valid(valid),
        .ready(ready), .cts(cts), .tx(tx), .done(done), .busy(busy)
    );

    uart_tx #(.CLKS_PER_BIT(CPB2), .STOP_BITS(2)) u_dut2 (
        .CLK(CLK), .reset(reset), .data_in(data2), .valid(valid2),
        .ready(ready2), .cts(cts), .tx(tx2), .done(done2), .busy(busy2)
    );

    always #5 CLK = ~CLK;

    // Expected TXD level k cycles after the accepting edge.
    function automatic logic exp_tx(input logic [7:0] d, input int k, input int cpb);
        int b;
        b = k / cpb;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (PB == 1 && b == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        cts   = 1'b0;
        repeat (2) @(negedge CLK);
        checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        reset = 1'b0;
        @(negedge CLK);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready_c1: got %b expected 0", ready); end
        @(negedge CLK);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready_c2: got %b expected 1", ready); end
        checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL reset_ready2: got %b expected 1", ready2); end
    endtask

    task automatic test_basic();
        data_in = 8'h55;
        valid   = 1'b1;
        @(negedge CLK);
        valid = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            checks++; if (tx !== exp_tx(8'h55, k, CPB)) begin errors++; $display("FAIL basic_tx cyc %0d: got %b expected %b", k, tx, exp_tx(8'h55, k, CPB)); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_early cyc %0d: got %b expected 0", k, done); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy cyc %0d: got %b expected 1", k, busy); end
            if (k == 0) begin
                checks++; if (ready !== 1'b0) begin errors++; $display("FAIL basic_ready_busy: got %b expected 0", ready); end
            end
            @(negedge CLK);
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
        checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL basic_tx_end: got %b expected 1", tx); end
        @(negedge CLK);
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b expected 1", ready); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] bytes [2];
        logic       pexp  [2];
        bytes[0] = 8'h07; pexp[0] = 1'b1;
        bytes[1] = 8'h03; pexp[1] = 1'b0;
        for (int n = 0; n < 2; n++) begin
            data_in = bytes[n];
            valid   = 1'b1;
            @(negedge CLK);
            valid = 1'b0;
            for (int k = 0; k < FRAME; k++) begin
                if (k / CPB == 9) begin
                    checks++; if (tx !== pexp[n]) begin errors++; $display("FAIL parity_bit %h cyc %0d: got %b expected %b", bytes[n], k, tx, pexp[n]); end
                end else begin
                    checks++; if (tx !== exp_tx(bytes[n], k, CPB)) begin errors++; $display("FAIL parity_tx %h cyc %0d: got %b expected %b", bytes[n], k, tx, exp_tx(bytes[n], k, CPB)); end
                end
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL parity_done_early cyc %0d: got %b expected 0", k, done); end
                @(negedge CLK);
            end
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL parity_done %h: got %b expected 1", bytes[n], done); end
            @(negedge CLK);
        end
    endtask
`endif

    task automatic test_back_to_back();
        data_in = 8'hA5;
        valid   = 1'b1;
        @(negedge CLK);
        data_in = 8'h3C;
        for (int k = 0; k < FRAME; k++) begin
            checks++; if (tx !== exp_tx(8'hA5, k, CPB)) begin errors++; $display("FAIL b2b_first cyc %0d: got %b expected %b", k, tx, exp_tx(8'hA5, k, CPB)); end
            @(negedge CLK);
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b expected 1", done); end
        checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL b2b_gap_tx: got %b expected 1", tx); end
        @(negedge CLK);
        valid = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            checks++; if (tx !== exp_tx(8'h3C, k, CPB)) begin errors++; $display("FAIL b2b_second cyc %0d: got %b expected %b", k, tx, exp_tx(8'h3C, k, CPB)); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy cyc %0d: got %b expected 1", k, busy); end
            @(negedge CLK);
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b expected 1", done); end
        @(negedge CLK);
    endtask

    task automatic test_flow_control();
        cts = 1'b1;
        repeat (3) @(negedge CLK);
        data_in = 8'h96;
        valid   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            checks++; if (ready !== 1'b0) begin errors++; $display("FAIL flow_ready_blocked cyc %0d: got %b expected 0", i, ready); end
            checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL flow_tx_idle cyc %0d: got %b expected 1", i, tx); end
            checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL flow_busy cyc %0d: got %b expected 0", i, busy); end
        end
        cts = 1'b0;
        @(negedge CLK);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL flow_ready_lat1: got %b expected 0", ready); end
        @(negedge CLK);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL flow_ready_lat2: got %b expected 1", ready); end
        checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL flow_tx_prestart: got %b expected 1", tx); end
        @(negedge CLK);
        valid = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            if (k == 5) cts = 1'b1;
            checks++; if (tx !== exp_tx(8'h96, k, CPB)) begin errors++; $display("FAIL flow_tx cyc %0d: got %b expected %b", k, tx, exp_tx(8'h96, k, CPB)); end
            @(negedge CLK);
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL flow_done: got %b expected 1", done); end
        @(negedge CLK);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL flow_ready_after: got %b expected 0", ready); end
        cts = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_reset_mid_frame();
        data_in = 8'h00;
        valid   = 1'b1;
        @(negedge CLK);
        valid = 1'b0;
        for (int k = 0; k < 18; k++) begin
            checks++; if (tx !== exp_tx(8'h00, k, CPB)) begin errors++; $display("FAIL rstmid_tx cyc %0d: got %b expected %b", k, tx, exp_tx(8'h00, k, CPB)); end
            if (k == 17) reset = 1'b1;
            @(negedge CLK);
        end
        reset = 1'b0;
        checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL rstmid_tx_after: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        for (int i = 0; i < 60; i++) begin
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done cyc %0d: got %b expected 0", i, done); end
            checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL rstmid_tx_idle cyc %0d: got %b expected 1", i, tx); end
            if (i < 2) begin
                checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_sync cyc %0d: got %b expected 0", i, ready); end
            end else if (i == 2) begin
                checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_back: got %b expected 1", ready); end
            end
            @(negedge CLK);
        end
        data_in = 8'hFF;
        valid   = 1'b1;
        @(negedge CLK);
        valid = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            checks++; if (tx !== exp_tx(8'hFF, k, CPB)) begin errors++; $display("FAIL rstmid_ff cyc %0d: got %b expected %b", k, tx, exp_tx(8'hFF, k, CPB)); end
            @(negedge CLK);
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rstmid_ff_done: got %b expected 1", done); end
        @(negedge CLK);
    endtask

    task automatic test_two_stop_bits();
        checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL stop2_ready: got %b expected 1", ready2); end
        data2  = 8'h80;
        valid2 = 1'b1;
        @(negedge CLK);
        valid2 = 1'b0;
        for (int k = 0; k < FRAME2; k++) begin
            checks++; if (tx2 !== exp_tx(8'h80, k, CPB2)) begin errors++; $display("FAIL stop2_tx cyc %0d: got %b expected %b", k, tx2, exp_tx(8'h80, k, CPB2)); end
            checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL stop2_done_early cyc %0d: got %b expected 0", k, done2); end
            @(negedge CLK);
        end
        checks++; if (done2 !== 1'b1) begin errors++; $display("FAIL stop2_done: got %b expected 1", done2); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL stop2_busy_end: got %b expected 0", busy2); end
        @(negedge CLK);
        checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL stop2_done_pulse: got %b expected 0", done2); end
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_flow_control();
        test_reset_mid_frame();
        test_two_stop_bits();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
